// File: rtl/booth_mpy_accum.sv
// Frame accumulator behind the 32x32 signed Booth multiplier.
// Each rising edge of mpy_valid contributes one product. After CNT_N products the frame sum
// is offered on acc_out/acc_valid until it is accepted. One product that arrives while the
// result is waiting is held in a skid register. Any further product is dropped and flagged.
module booth_mpy_accum #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_N = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    clr,
  input  logic signed [63:0]      mpy_out,
  input  logic                    mpy_valid,
  input  logic                    acc_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  output logic [CW-1:0]           prod_cnt,
  output logic                    ovf,
  output logic                    lost,
  output logic                    pend
);

  typedef enum logic {StAccum, StHold} state_e;

  localparam logic [CW-1:0] CntLast = CW'(CNT_N);
  localparam logic [CW-1:0] CntTwo  = CW'(2);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    lost_q, lost_d;
  logic                    pend_q, pend_d;
  logic signed [63:0]      skid_q, skid_d;
  logic                    v_d;  // valid history for rising-edge detection

  logic                    hit;
  logic signed [ACC_W-1:0] prod_ext, skid_ext;
  logic signed [ACC_W-1:0] sum_acc, sum_skid;
  logic                    ovf_acc, ovf_skid;
  logic [CW-1:0]           cnt_inc;

  // Edge detect, sign extension and the two candidate sums with their overflow flags.
  always_comb begin
    hit      = mpy_valid & ~v_d;
    prod_ext = ACC_W'(mpy_out);
    skid_ext = ACC_W'(skid_q);
    sum_acc  = acc_q + prod_ext;
    sum_skid = skid_ext + prod_ext;
    ovf_acc  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_acc[ACC_W-1] != acc_q[ACC_W-1]);
    ovf_skid = (skid_ext[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_skid[ACC_W-1] != skid_ext[ACC_W-1]);
    cnt_inc  = cnt_q + CntOne;
  end

  // Next-state logic for the ACCUM/HOLD machine and all datapath registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    lost_d  = lost_q;
    pend_d  = pend_q;
    skid_d  = skid_q;

    if (clr) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      lost_d  = 1'b0;
      pend_d  = 1'b0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (hit) begin
            acc_d = sum_acc;
            cnt_d = cnt_inc;
            if (ovf_acc) ovf_d = 1'b1;
            if (cnt_inc == CntLast) begin
              state_d = StHold;
              valid_d = 1'b1;
            end
          end
        end
        StHold: begin
          if (acc_ready) begin
            // Result consumed: start the next frame from whatever is pending right now.
            state_d = StAccum;
            valid_d = 1'b0;
            pend_d  = 1'b0;
            unique case ({pend_q, hit})
              2'b00: begin
                acc_d = '0;
                cnt_d = '0;
              end
              2'b10: begin
                acc_d = skid_ext;
                cnt_d = CntOne;
              end
              2'b01: begin
                acc_d = prod_ext;
                cnt_d = CntOne;
              end
              default: begin
                acc_d = sum_skid;
                cnt_d = CntTwo;
                if (ovf_skid) ovf_d = 1'b1;
                if (CntTwo == CntLast) begin
                  state_d = StHold;
                  valid_d = 1'b1;
                end
              end
            endcase
          end else if (hit) begin
            if (!pend_q) begin
              skid_d = mpy_out;
              pend_d = 1'b1;
            end else begin
              lost_d = 1'b1;
            end
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  // State and datapath registers; v_d follows mpy_valid except under clr.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
      pend_q  <= 1'b0;
      skid_q  <= '0;
      v_d     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
      pend_q  <= pend_d;
      skid_q  <= skid_d;
      v_d     <= clr ? 1'b0 : mpy_valid;
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = valid_q;
  assign prod_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign lost      = lost_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_booth_mpy_accum.sv
// Directed bench for booth_mpy_accum: a default instance (72-bit, 4 per frame) and a
// 64-bit, 2-per-frame instance for overflow and skid-plus-hit restart. Frame results are
// scoreboarded; intermediate state is checked directly.
module tb_booth_mpy_accum;

  logic CLK;
  logic reset;

  // Default instance
  logic        clr0, vld0, rdy0;
  logic [63:0] mpy0;
  logic [71:0] acc0;
  logic        aval0, ovf0, lost0, pend0;
  logic [7:0]  cnt0;

  // 64-bit, two-product instance
  logic        clr1, vld1, rdy1;
  logic [63:0] mpy1;
  logic [63:0] acc1;
  logic        aval1, ovf1, lost1, pend1;
  logic [7:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0] q0[$];
  logic [71:0] q1[$];

  booth_mpy_accum u_dut (
    .CLK      (CLK),
    .reset    (reset),
    .clr      (clr0),
    .mpy_out  (mpy0),
    .mpy_valid(vld0),
    .acc_ready(rdy0),
    .acc_out  (acc0),
    .acc_valid(aval0),
    .prod_cnt (cnt0),
    .ovf      (ovf0),
    .lost     (lost0),
    .pend     (pend0)
  );

  booth_mpy_accum #(
    .ACC_W(64),
    .CNT_N(2),
    .CW   (8)
  ) u_ovf (
    .CLK      (CLK),
    .reset    (reset),
    .clr      (clr1),
    .mpy_out  (mpy1),
    .mpy_valid(vld1),
    .acc_ready(rdy1),
    .acc_out  (acc1),
    .acc_valid(aval1),
    .prod_cnt (cnt1),
    .ovf      (ovf1),
    .lost     (lost1),
    .pend     (pend1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse0(input logic [63:0] v);
    mpy0 = v;
    vld0 = 1'b1;
    step(1);
    vld0 = 1'b0;
    step(1);
  endtask

  task automatic pulse1(input logic [63:0] v);
    mpy1 = v;
    vld1 = 1'b1;
    step(1);
    vld1 = 1'b0;
    step(1);
  endtask

  // Frame monitors: compare each accepted frame against the scoreboard.
  always @(negedge CLK) begin
    if (!reset && !clr0 && aval0 && rdy0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame0 unexpected: got %0h expected none", acc0);
      end else begin
        chk("frame0", acc0, q0.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (!reset && !clr1 && aval1 && rdy1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame1 unexpected: got %0h expected none", acc1);
      end else begin
        chk("frame1", {8'h0, acc1}, q1.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr0 = 0; vld0 = 0; rdy0 = 0; mpy0 = '0;
    clr1 = 0; vld1 = 0; rdy1 = 0; mpy1 = '0;
    step(3);
    chk("rst acc", acc0, 72'd0);
    chk("rst valid", {71'd0, aval0}, 72'd0);
    reset = 1'b0;
    step(1);
    chk("rst cnt", {64'd0, cnt0}, 72'd0);
    chk("rst flags", {69'd0, ovf0, lost0, pend0}, 72'd0);

    // Held level counts once; acc_ready in ACCUM is ignored
    mpy0 = 64'd2700;
    vld0 = 1'b1;
    step(1);
    chk("held first acc", acc0, 72'd2700);
    chk("held first cnt", {64'd0, cnt0}, 72'd1);
    rdy0 = 1'b1;
    step(4);
    chk("held acc", acc0, 72'd2700);
    chk("held cnt", {64'd0, cnt0}, 72'd1);
    rdy0 = 1'b0;
    vld0 = 1'b0;
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk("clr acc", acc0, 72'd0);

    // Signed frame summing to zero
    pulse0(64'd2700);
    pulse0(-64'sd2700);
    pulse0(-64'sd2700);
    mpy0 = 64'd2700;
    vld0 = 1'b1;
    step(1);
    vld0 = 1'b0;
    chk("frame valid", {71'd0, aval0}, 72'd1);
    chk("frame acc", acc0, 72'd0);
    chk("frame cnt", {64'd0, cnt0}, 72'd4);
    q0.push_back(72'd0);
    rdy0 = 1'b1;
    step(1);
    rdy0 = 1'b0;
    chk("hs valid", {71'd0, aval0}, 72'd0);
    chk("hs cnt", {64'd0, cnt0}, 72'd0);
    step(1);

    // Skid and drop
    repeat (4) pulse0(64'd2700);
    chk("skid frame acc", acc0, 72'd10800);
    chk("skid frame valid", {71'd0, aval0}, 72'd1);
    pulse0(-64'sd2700);
    chk("skid pend", {71'd0, pend0}, 72'd1);
    chk("skid lost0", {71'd0, lost0}, 72'd0);
    pulse0(64'd2700);
    chk("drop lost", {71'd0, lost0}, 72'd1);
    chk("drop pend", {71'd0, pend0}, 72'd1);
    chk("drop acc", acc0, 72'd10800);
    chk("drop cnt", {64'd0, cnt0}, 72'd4);
    q0.push_back(72'd10800);
    rdy0 = 1'b1;
    step(1);
    rdy0 = 1'b0;
    chk("skid restart acc", acc0, 72'hFF_FFFF_FFFF_FFFF_F574);
    chk("skid restart cnt", {64'd0, cnt0}, 72'd1);
    chk("skid restart pend", {71'd0, pend0}, 72'd0);
    chk("lost sticky", {71'd0, lost0}, 72'd1);

    // Handshake coinciding with a hit while the skid is full
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk("clr lost", {71'd0, lost0}, 72'd0);
    pulse0(64'd100);
    pulse0(64'd200);
    pulse0(64'd300);
    pulse0(64'd400);
    pulse0(64'd2700);
    chk("sim pend", {71'd0, pend0}, 72'd1);
    q0.push_back(72'd1000);
    mpy0 = 64'd900;
    vld0 = 1'b1;
    rdy0 = 1'b1;
    step(1);
    vld0 = 1'b0;
    rdy0 = 1'b0;
    chk("sim acc", acc0, 72'd3600);
    chk("sim cnt", {64'd0, cnt0}, 72'd2);
    chk("sim valid", {71'd0, aval0}, 72'd0);
    chk("sim pend clr", {71'd0, pend0}, 72'd0);
    step(1);
    pulse0(64'd1);
    pulse0(64'd2);
    chk("sim next acc", acc0, 72'd3603);
    chk("sim next valid", {71'd0, aval0}, 72'd1);
    q0.push_back(72'd3603);
    rdy0 = 1'b1;
    step(1);
    rdy0 = 1'b0;
    chk("sim next drain", acc0, 72'd0);

    // Async reset mid-frame
    pulse0(64'd5);
    pulse0(64'd6);
    chk("pre-reset acc", acc0, 72'd11);
    #2 reset = 1'b1;
    #1;
    chk("async rst acc", acc0, 72'd0);
    chk("async rst cnt", {64'd0, cnt0}, 72'd0);
    step(1);
    reset = 1'b0;
    step(1);
    pulse0(64'd7);
    pulse0(64'd8);
    chk("post-reset acc", acc0, 72'd15);
    chk("post-reset cnt", {64'd0, cnt0}, 72'd2);
    chk("post-reset valid", {71'd0, aval0}, 72'd0);

    // clr together with a hit: hit ignored, still-high level counts afterwards
    mpy0 = 64'd50;
    vld0 = 1'b1;
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk("clr hit acc", acc0, 72'd0);
    chk("clr hit cnt", {64'd0, cnt0}, 72'd0);
    step(1);
    chk("recount acc", acc0, 72'd50);
    chk("recount cnt", {64'd0, cnt0}, 72'd1);
    vld0 = 1'b0;
    step(1);

    // Overflow on the 64-bit instance
    pulse1(64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf first", {71'd0, ovf1}, 72'd0);
    pulse1(64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf acc", {8'h0, acc1}, {8'h0, 64'hFFFF_FFFF_FFFF_FFFE});
    chk("ovf flag", {71'd0, ovf1}, 72'd1);
    chk("ovf valid", {71'd0, aval1}, 72'd1);
    q1.push_back({8'h0, 64'hFFFF_FFFF_FFFF_FFFE});
    rdy1 = 1'b1;
    step(1);
    rdy1 = 1'b0;
    pulse1(64'd1);
    chk("ovf next acc", {8'h0, acc1}, 72'd1);
    chk("ovf sticky", {71'd0, ovf1}, 72'd1);
    pulse1(64'd2);
    pulse1(64'd10);
    chk("n2 pend", {71'd0, pend1}, 72'd1);
    q1.push_back(72'd3);
    mpy1 = 64'd20;
    vld1 = 1'b1;
    rdy1 = 1'b1;
    step(1);
    vld1 = 1'b0;
    chk("n2 rehold acc", {8'h0, acc1}, 72'd30);
    chk("n2 rehold cnt", {64'd0, cnt1}, 72'd2);
    chk("n2 rehold valid", {71'd0, aval1}, 72'd1);
    q1.push_back(72'd30);
    step(1);
    rdy1 = 1'b0;
    chk("n2 drain valid", {71'd0, aval1}, 72'd0);
    chk("n2 drain acc", {8'h0, acc1}, 72'd0);
    clr1 = 1'b1;
    step(1);
    clr1 = 1'b0;
    chk("ovf clr", {71'd0, ovf1}, 72'd0);

    step(2);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frames missing: got %0d outstanding expected 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_mpy_accum.md
Name: booth_mpy_accum

Overview:
- Downstream consumer of the 32x32 signed Booth multiplier.
- Watches the multiplier's 64-bit product and its out_valid level, and accepts each product exactly once on the rising edge of valid.
- Sign-extends and accumulates CNT_N products into a wide signed accumulator, then presents the frame sum through a valid/ready handshake.
- Buffers one product that arrives while the frame result is waiting to be consumed.

Parameters:
- ACC_W, 72, accumulator width in bits. Must be ≥ 64.
- CNT_N, 4, products per frame. Must be ≥ 2.
- CW, 8, width of prod_cnt. Must satisfy 2^CW > CNT_N.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; highest priority after reset.
- mpy_out  input  64  signed product from the multiplier.
- mpy_valid  input  1  multiplier out_valid. It is a level and may stay high for many cycles.
- acc_ready  input  1  consumer ready.
- acc_out  output  ACC_W  signed frame accumulator.
- acc_valid  output  1  frame complete; held until accepted.
- prod_cnt  output  CW  products accumulated in the current frame.
- ovf  output  1  sticky signed-overflow flag.
- lost  output  1  sticky flag: a product was dropped.
- pend  output  1  a product is held in the skid register.

Behaviour:
- Reset (async): all of the following are 0: acc_out, acc_valid, prod_cnt, ovf, lost, pend, the skid register and the valid-history register v_d. State = ACCUM.
- Edge detect:
  - v_d <= mpy_valid every cycle.
  - hit = mpy_valid & ~v_d.
  - One product per rising edge. A held level never re-counts.
  - v_d is also cleared by clr. A level still high after clr therefore counts once more.
- State machine: ACCUM and HOLD.
- ACCUM, on hit:
  - acc_out <= acc_out + sext(mpy_out), with the sum in ACC_W bits (wraps).
  - prod_cnt increments.
  - If the updated count equals CNT_N: go to HOLD and set acc_valid = 1 at that same edge.
  - Latency: acc_out is updated at the edge that samples the mpy_valid rise (1 cycle).
- HOLD:
  - acc_out and prod_cnt are frozen and acc_valid = 1.
  - A hit with pend = 0 and no handshake: store mpy_out in skid, pend <= 1.
  - A hit with pend = 1 and no handshake: drop the product and set lost <= 1.
- Handshake in HOLD (acc_valid & acc_ready), same edge:
  - acc_valid <= 0; go to ACCUM; pend <= 0.
  - New accumulator contents by case:
    - No pend, no hit: acc = 0, cnt = 0.
    - Pend only: acc = sext(skid), cnt = 1.
    - Hit only: acc = sext(mpy_out), cnt = 1.
    - Pend and hit: acc = sext(skid) + sext(mpy_out), cnt = 2. If CNT_N = 2, go directly back to HOLD with acc_valid = 1.
- acc_ready while in ACCUM is ignored.
- Overflow:
  - An add whose operands have equal sign and whose result sign differs sets ovf.
  - The result still wraps.
  - ovf persists across frames until clr or reset.
- clr:
  - Zeroes acc_out, prod_cnt, acc_valid, pend, skid, ovf, lost and v_d.
  - State = ACCUM.
  - Any hit or acc_ready in the same cycle is ignored.
- Reset mid-frame: partial sum discarded; no acc_valid is produced.

Test Plan:
- Single held valid: mpy_valid high for 5 cycles with mpy_out = 2700 -> acc_out = 2700 after one edge, prod_cnt = 1; no further change.
- Signed frame: four pulses with products 2700, -2700, -2700, 2700 -> after the 4th edge acc_valid = 1, acc_out = 0, prod_cnt = 4; acc_ready = 1 -> acc_valid drops next edge, acc_out = 0, prod_cnt = 0.
- Skid and drop:
  - Complete a frame summing to 10800.
  - With acc_ready low, pulse -2700 -> pend = 1.
  - Pulse 2700 -> lost = 1, pend stays 1, acc_out stays 10800.
  - Raise acc_ready -> acc_out = -2700 (sign-extended to 72 bits), prod_cnt = 1, pend = 0.
- Simultaneous handshake: pend holds 2700; a hit of 900 coincides with acc_ready -> acc_out = 3600, prod_cnt = 2, state ACCUM.
- Overflow (ACC_W = 64 instance): add 64'h7FFF_FFFF_FFFF_FFFF twice -> acc_out = 64'hFFFF_FFFF_FFFF_FFFE and ovf = 1; ovf stays 1 into the next frame and is cleared by clr.
- Reset/clr mid-frame: after 2 products, assert reset asynchronously between edges -> all outputs 0 immediately. Repeat with clr coinciding with a hit -> outputs 0 and the hit is not counted.
